// File: rtl/uart_tx_buffered_pkg.sv
// Shared UART definitions: frame states, data width, default bit period.
// Kept common with the receiver so both ends agree on the line format.
package uart_tx_buffered_pkg;

    localparam int UART_DATA_BITS   = 8;
    localparam int DEF_CLKS_PER_BIT = 217;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_t;

endpackage

// File: rtl/uart_tx_buffered_if.sv
// Host-side bundle of the buffered UART transmitter.
// master = host logic, slave = transmitter.
interface uart_tx_buffered_if
    import uart_tx_buffered_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic                      i_TX_DV;
    logic [UART_DATA_BITS-1:0] i_TX_Byte;
    logic                      o_TX_Ready;
    logic                      o_TX_Serial;
    logic                      o_TX_Active;
    logic                      o_TX_Done;
    logic [CW-1:0]             o_FIFO_Count;

    modport master (
        output i_TX_DV,
        output i_TX_Byte,
        input  o_TX_Ready,
        input  o_TX_Serial,
        input  o_TX_Active,
        input  o_TX_Done,
        input  o_FIFO_Count
    );

    modport slave (
        input  i_TX_DV,
        input  i_TX_Byte,
        output o_TX_Ready,
        output o_TX_Serial,
        output o_TX_Active,
        output o_TX_Done,
        output o_FIFO_Count
    );

endinterface

// File: rtl/uart_tx_buffered_fifo.sv
// Small synchronous byte FIFO feeding the transmitter.
// A push while full is dropped even if a pop happens the same cycle.
module uart_tx_buffered_fifo
    import uart_tx_buffered_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
)(
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      push,
    input  logic [UART_DATA_BITS-1:0] wdata,
    input  logic                      pop,
    output logic [UART_DATA_BITS-1:0] rdata,
    output logic                      full,
    output logic                      empty,
    output logic [CW-1:0]             count
);

    logic [UART_DATA_BITS-1:0] mem [DEPTH];
    logic [AW-1:0]             wr_ptr;
    logic [AW-1:0]             rd_ptr;
    logic                      push_ok;
    logic                      pop_ok;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + CW'(push_ok) - CW'(pop_ok);
        end
    end

endmodule

// File: rtl/uart_tx_buffered.sv
// Buffered 8N1 UART transmitter: frame FSM, bit timer, shifter.
// Line outputs are registered, so the start bit lags the pop by one edge.
module uart_tx_buffered
    import uart_tx_buffered_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
    parameter int FIFO_DEPTH   = 4
)(
    input  logic               i_Clock,
    input  logic               i_Reset,
    uart_tx_buffered_if.slave  bus
);

    localparam int PW = $clog2(CLKS_PER_BIT);
    localparam int BW = $clog2(UART_DATA_BITS);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [PW-1:0] P_LAST = PW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] B_LAST = BW'(UART_DATA_BITS - 1);

    tx_state_t                 state;
    tx_state_t                 state_n;
    logic [PW-1:0]             tick;
    logic [PW-1:0]             tick_n;
    logic [BW-1:0]             bit_idx;
    logic [BW-1:0]             bit_n;
    logic [UART_DATA_BITS-1:0] shift;
    logic [UART_DATA_BITS-1:0] shift_n;
    logic [UART_DATA_BITS-1:0] head;
    logic                      pop;
    logic                      line;
    logic                      active_n;
    logic                      done_n;
    logic                      serial_q;
    logic                      active_q;
    logic                      done_q;
    logic                      full;
    logic                      empty;
    logic [CW-1:0]             count;

    uart_tx_buffered_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (i_Clock),
        .rst   (i_Reset),
        .push  (bus.i_TX_DV),
        .wdata (bus.i_TX_Byte),
        .pop   (pop),
        .rdata (head),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    assign bus.o_TX_Ready   = !full;
    assign bus.o_FIFO_Count = count;
    assign bus.o_TX_Serial  = serial_q;
    assign bus.o_TX_Active  = active_q;
    assign bus.o_TX_Done    = done_q;

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            state    <= ST_IDLE;
            tick     <= '0;
            bit_idx  <= '0;
            shift    <= '0;
            serial_q <= 1'b1;
            active_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state    <= state_n;
            tick     <= tick_n;
            bit_idx  <= bit_n;
            shift    <= shift_n;
            serial_q <= line;
            active_q <= active_n;
            done_q   <= done_n;
        end
    end

    always_comb begin
        state_n  = state;
        tick_n   = tick;
        bit_n    = bit_idx;
        shift_n  = shift;
        pop      = 1'b0;
        line     = 1'b1;
        active_n = 1'b1;
        done_n   = 1'b0;
        unique case (state)
            ST_IDLE: begin
                active_n = 1'b0;
                tick_n   = '0;
                bit_n    = '0;
                if (!empty) begin
                    pop     = 1'b1;
                    shift_n = head;
                    state_n = ST_START;
                end
            end
            ST_START: begin
                line = 1'b0;
                if (tick == P_LAST) begin
                    tick_n  = '0;
                    state_n = ST_DATA;
                end else begin
                    tick_n = tick + PW'(1);
                end
            end
            ST_DATA: begin
                line = shift[0];
                if (tick == P_LAST) begin
                    tick_n  = '0;
                    shift_n = shift >> 1;
                    if (bit_idx == B_LAST) begin
                        state_n = ST_STOP;
                    end else begin
                        bit_n = bit_idx + BW'(1);
                    end
                end else begin
                    tick_n = tick + PW'(1);
                end
            end
            ST_STOP: begin
                if (tick == P_LAST) begin
                    tick_n = '0;
                    done_n = 1'b1;
                    // Chain straight into the next frame when more is queued.
                    if (!empty) begin
                        pop     = 1'b1;
                        shift_n = head;
                        bit_n   = '0;
                        state_n = ST_START;
                    end else begin
                        state_n = ST_IDLE;
                    end
                end else begin
                    tick_n = tick + PW'(1);
                end
            end
            default: begin
                active_n = 1'b0;
                state_n  = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Directed bench for uart_tx_buffered: framing, FIFO, reset, loopback.
module tb_uart_tx_buffered;
    import uart_tx_buffered_pkg::*;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;
    localparam int CPB2  = 217;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    uart_tx_buffered_if #(.FIFO_DEPTH(DEPTH)) bus ();
    uart_tx_buffered_if #(.FIFO_DEPTH(DEPTH)) bus2 ();

    uart_tx_buffered #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .i_Clock (clk),
        .i_Reset (rst),
        .bus     (bus.slave)
    );

    uart_tx_buffered #(
        .CLKS_PER_BIT (CPB2),
        .FIFO_DEPTH   (DEPTH)
    ) dut2 (
        .i_Clock (clk),
        .i_Reset (rst),
        .bus     (bus2.slave)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    logic       peak_clr = 1'b1;
    logic [2:0] peak;
    always @(negedge clk) begin
        if (peak_clr) peak <= '0;
        else if (bus.o_FIFO_Count > peak) peak <= bus.o_FIFO_Count;
    end

    task automatic push_seq(input logic [7:0] v [8], input int n,
                            output int not_ready);
        not_ready = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (!bus.o_TX_Ready) not_ready++;
            bus.i_TX_DV   = 1'b1;
            bus.i_TX_Byte = v[i];
        end
        @(negedge clk);
        bus.i_TX_DV = 1'b0;
    endtask

    task automatic wait_fall(input string tag);
        bit seen = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(posedge clk);
            #1;
            if (!bus.o_TX_Serial) begin
                seen = 1'b1;
                break;
            end
        end
        check({tag, "_start"}, 32'(seen), 32'd1);
    endtask

    task automatic check_frame(input logic [7:0] b, input string tag);
        int         bad = 0;
        int         dn  = 0;
        logic [9:0] fr;
        fr = {1'b1, b, 1'b0};
        for (int k = 0; k < 10 * CPB; k++) begin
            @(negedge clk);
            if (bus.o_TX_Serial !== fr[k / CPB]) bad++;
            if (bus.o_TX_Active !== 1'b1) bad++;
            if (bus.o_TX_Done === 1'b1) begin
                if (k == 10 * CPB - 1) dn++;
                else bad++;
            end
        end
        check({tag, "_line"}, 32'(bad), 32'd0);
        check({tag, "_done"}, 32'(dn), 32'd1);
    endtask

    task automatic rx_byte(output logic [7:0] b, output bit ok);
        bit seen = 1'b0;
        ok = 1'b1;
        b  = '0;
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            if (!bus2.o_TX_Serial) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) ok = 1'b0;
        repeat (CPB2 / 2) @(negedge clk);
        if (bus2.o_TX_Serial !== 1'b0) ok = 1'b0;
        for (int i = 0; i < 8; i++) begin
            repeat (CPB2) @(negedge clk);
            b[i] = bus2.o_TX_Serial;
        end
        repeat (CPB2) @(negedge clk);
        if (bus2.o_TX_Serial !== 1'b1) ok = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] v [8];
        logic [7:0] r0;
        logic [7:0] r1;
        bit         ok0;
        bit         ok1;
        int         nr;
        int         bad;

        bus.i_TX_DV    = 1'b0;
        bus.i_TX_Byte  = '0;
        bus2.i_TX_DV   = 1'b0;
        bus2.i_TX_Byte = '0;

        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_serial", 32'(bus.o_TX_Serial), 32'd1);
        check("rst_ready",  32'(bus.o_TX_Ready),  32'd1);
        check("rst_count",  32'(bus.o_FIFO_Count), 32'd0);
        check("rst_active", 32'(bus.o_TX_Active), 32'd0);
        check("rst_done",   32'(bus.o_TX_Done),   32'd0);
        @(negedge clk);
        rst = 1'b0;

        v = '{8'hA5, 0, 0, 0, 0, 0, 0, 0};
        push_seq(v, 1, nr);
        check("a5_count", 32'(bus.o_FIFO_Count), 32'd1);
        @(posedge clk);
        #1;
        check("a5_lat_e1", 32'(bus.o_TX_Serial), 32'd1);
        @(posedge clk);
        #1;
        check("a5_lat_e2", 32'(bus.o_TX_Serial), 32'd0);
        check_frame(8'hA5, "a5");
        @(negedge clk);
        check("a5_idle_line",   32'(bus.o_TX_Serial), 32'd1);
        check("a5_idle_active", 32'(bus.o_TX_Active), 32'd0);

        repeat (3) @(negedge clk);
        peak_clr = 1'b0;
        v = '{8'h00, 8'hFF, 8'h55, 8'h0F, 0, 0, 0, 0};
        fork
            push_seq(v, 4, nr);
            begin
                wait_fall("b2b");
                check_frame(8'h00, "b2b0");
                check_frame(8'hFF, "b2b1");
                check_frame(8'h55, "b2b2");
                check_frame(8'h0F, "b2b3");
            end
        join
        check("b2b_accept", 32'(nr), 32'd0);
        check("b2b_peak",   32'(peak), 32'd3);
        @(negedge clk);
        check("b2b_idle", 32'(bus.o_TX_Active), 32'd0);

        peak_clr = 1'b1;
        repeat (3) @(negedge clk);
        peak_clr = 1'b0;
        v = '{8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 0, 0};
        fork
            begin
                push_seq(v, 6, nr);
                check("ovf_ready_low", 32'(bus.o_TX_Ready), 32'd0);
                check("ovf_count_full", 32'(bus.o_FIFO_Count), 32'd4);
            end
            begin
                wait_fall("ovf");
                check_frame(8'h11, "ovf0");
                check_frame(8'h12, "ovf1");
                check_frame(8'h13, "ovf2");
                check_frame(8'h14, "ovf3");
                check_frame(8'h15, "ovf4");
            end
        join
        check("ovf_refused", 32'(nr), 32'd1);
        check("ovf_peak", 32'(peak), 32'd4);
        bad = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (bus.o_TX_Serial !== 1'b1 || bus.o_TX_Active !== 1'b0) bad++;
        end
        check("ovf_dropped_idle", 32'(bad), 32'd0);
        check("ovf_ready_back", 32'(bus.o_TX_Ready), 32'd1);
        check("ovf_count_zero", 32'(bus.o_FIFO_Count), 32'd0);

        v = '{8'h81, 8'h42, 0, 0, 0, 0, 0, 0};
        fork
            push_seq(v, 2, nr);
            wait_fall("mid");
        join
        repeat (4 * CPB + 1) @(negedge clk);
        check("mid_bit3_low", 32'(bus.o_TX_Serial), 32'd0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("mid_line",   32'(bus.o_TX_Serial), 32'd1);
        check("mid_active", 32'(bus.o_TX_Active), 32'd0);
        check("mid_count",  32'(bus.o_FIFO_Count), 32'd0);
        check("mid_done",   32'(bus.o_TX_Done), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        bad = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (bus.o_TX_Serial !== 1'b1 || bus.o_TX_Done !== 1'b0 ||
                bus.o_TX_Active !== 1'b0) bad++;
        end
        check("mid_quiet", 32'(bad), 32'd0);
        v = '{8'h3C, 0, 0, 0, 0, 0, 0, 0};
        fork
            push_seq(v, 1, nr);
            begin
                wait_fall("post");
                check_frame(8'h3C, "post3c");
            end
        join

        fork
            begin
                @(negedge clk);
                bus2.i_TX_DV   = 1'b1;
                bus2.i_TX_Byte = 8'h5A;
                @(negedge clk);
                bus2.i_TX_Byte = 8'hC3;
                @(negedge clk);
                bus2.i_TX_DV   = 1'b0;
            end
            begin
                rx_byte(r0, ok0);
                rx_byte(r1, ok1);
            end
        join
        check("loop_ok0",  32'(ok0), 32'd1);
        check("loop_byte0", 32'(r0), 32'h5A);
        check("loop_ok1",  32'(ok1), 32'd1);
        check("loop_byte1", 32'(r1), 32'hC3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
